// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and reference model for the CLA result checker
package cla_pkg;

    localparam int CLA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } chk_state_t;

    // Operands are zero-extended by the caller; the extra MSB keeps the carry.
    function automatic logic [32:0] cla_ref_sum(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic        cin);
        return {1'b0, a} + {1'b0, b} + {32'b0, cin};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cla_result_checker.sv
// rtl/cla_result_checker.sv - checks observed CLA adder results against a+b+cin
module cla_result_checker
    import cla_pkg::*;
#(
    parameter int WIDTH        = CLA_WIDTH,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_cin,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_cout,
    output logic                 chk_valid,
    output logic                 chk_pass,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 err_flag,
    output logic [3*WIDTH+1:0]   err_tuple,
    output logic [WIDTH:0]       err_expected
);

    chk_state_t       state, state_nxt;
    logic [WIDTH-1:0] s1_a, s1_b, s1_sum;
    logic             s1_cin, s1_cout;
    logic [WIDTH:0]   exp_res;
    logic             accept, s1_valid, match, pass_now, fail_now, halt_now;

    assign accept   = in_valid && in_ready;
    assign s1_valid = (state == CHECK);
    assign exp_res  = (WIDTH+1)'(cla_ref_sum(32'(s1_a), 32'(s1_b), s1_cin));
    assign match    = ({s1_cout, s1_sum} == exp_res);
    assign pass_now = s1_valid && match;
    assign fail_now = s1_valid && !match;
    assign halt_now = fail_now && STOP_ON_FAIL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A tuple accepted on the edge that enters HALT is dropped by not entering CHECK.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CHECK;
            CHECK:   if (halt_now)    state_nxt = HALT;
                     else if (accept) state_nxt = CHECK;
                     else             state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_comb begin
        in_ready = (state != HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s1_cin  <= 1'b0;
            s1_sum  <= '0;
            s1_cout <= 1'b0;
        end else if (accept) begin
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_cin  <= in_cin;
            s1_sum  <= in_sum;
            s1_cout <= in_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
        end else begin
            chk_valid <= s1_valid && !clear;
            chk_pass  <= pass_now && !clear;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag     <= 1'b0;
            err_tuple    <= '0;
            err_expected <= '0;
        end else if (clear) begin
            err_flag     <= 1'b0;
            err_tuple    <= '0;
            err_expected <= '0;
        end else if (fail_now && !err_flag) begin
            err_flag     <= 1'b1;
            err_tuple    <= {s1_a, s1_b, s1_cin, s1_sum, s1_cout};
            err_expected <= exp_res;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (pass_now),
        .count (pass_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (fail_now),
        .count (fail_cnt)
    );

endmodule

// File: tb/tb_cla_result_checker.sv
// tb/tb_cla_result_checker.sv - self-checking bench for cla_result_checker
module tb_cla_result_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = '0, in_b = '0, in_sum = '0;
    logic       in_cin = 1'b0, in_cout = 1'b0;

    logic        m_ready, m_cv, m_cp, m_ef;
    logic [15:0] m_pc, m_fc;
    logic [13:0] m_et;
    logic [4:0]  m_ee;
    logic        h_ready, h_cv, h_cp, h_ef;
    logic [15:0] h_pc, h_fc;
    logic [13:0] h_et;
    logic [4:0]  h_ee;
    logic        s_ready, s_cv, s_cp, s_ef;
    logic [3:0]  s_pc, s_fc;
    logic [13:0] s_et;
    logic [4:0]  s_ee;

    always #5 clk = ~clk;

    cla_result_checker u_main (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(m_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
        .chk_valid(m_cv), .chk_pass(m_cp), .pass_cnt(m_pc), .fail_cnt(m_fc),
        .err_flag(m_ef), .err_tuple(m_et), .err_expected(m_ee)
    );

    cla_result_checker #(.STOP_ON_FAIL(1'b1)) u_halt (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(h_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
        .chk_valid(h_cv), .chk_pass(h_cp), .pass_cnt(h_pc), .fail_cnt(h_fc),
        .err_flag(h_ef), .err_tuple(h_et), .err_expected(h_ee)
    );

    cla_result_checker #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
        .chk_valid(s_cv), .chk_pass(s_cp), .pass_cnt(s_pc), .fail_cnt(s_fc),
        .err_flag(s_ef), .err_tuple(s_et), .err_expected(s_ee)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        bit         exp_pass;
    } vec_t;

    int checks = 0;
    int passed = 0;
    int pulses = 0;
    bit sb[$];
    bit exp_p;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard for the default-parameter instance.
    always @(negedge clk) begin
        if (rst_n && m_cv) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected: chk_valid with no pending tuple, chk_pass=%0b", m_cp);
            end else begin
                exp_p = sb.pop_front();
                check("chk_pass", m_cp, exp_p);
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [3:0] s, input logic co, input bit ep);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sum = s; in_cout = co;
        if (m_ready) sb.push_back(ep);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_a = 4'($urandom); in_b = 4'($urandom); in_sum = 4'($urandom);
            in_cin = 1'($urandom); in_cout = 1'($urandom);
            @(negedge clk);
        end
    endtask

    // A tuple is presented alongside clear and must be discarded.
    task automatic do_clear();
        in_valid = 1'b1;
        in_a = 4'h2; in_b = 4'h2; in_cin = 1'b0; in_sum = 4'h4; in_cout = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        idle(2);
    endtask

    vec_t       tbl[6];
    logic [4:0] r;
    int         p0;

    initial begin
        tbl[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[1] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1};
        tbl[2] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1};
        tbl[3] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b1};
        tbl[4] = '{4'h5, 4'h5, 1'b0, 4'hA, 1'b1, 1'b0};
        tbl[5] = '{4'h9, 4'h6, 1'b0, 4'hF, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", m_ready, 1);
        check("rst_chk_valid", m_cv, 0);
        check("rst_chk_pass", m_cp, 0);
        check("rst_pass_cnt", m_pc, 0);
        check("rst_fail_cnt", m_fc, 0);
        check("rst_err_flag", m_ef, 0);
        check("rst_err_tuple", m_et, 0);
        check("rst_err_expected", m_ee, 0);
        check("rst_halt_ready", h_ready, 1);

        for (int i = 0; i < 512; i++) begin
            r = 5'((i >> 5) & 15) + 5'((i >> 1) & 15) + 5'(i & 1);
            send(4'((i >> 5) & 15), 4'((i >> 1) & 15), 1'(i & 1), r[3:0], r[4], 1'b1);
        end
        idle(3);
        check("sweep_pass_cnt", m_pc, 512);
        check("sweep_fail_cnt", m_fc, 0);
        check("sweep_err_flag", m_ef, 0);
        check("sweep_pulses", pulses, 512);
        check("sweep_sb_empty", sb.size(), 0);

        p0 = pulses;
        do_clear();
        check("clr_pass_cnt", m_pc, 0);
        check("clr_fail_cnt", m_fc, 0);
        check("clr_no_pulse", pulses, p0);

        // Latency: accepted at one edge, result visible after the next.
        send(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1);
        in_valid = 1'b0;
        check("lat_not_yet", m_cv, 0);
        @(negedge clk);
        check("lat_valid", m_cv, 1);
        check("lat_pass", m_cp, 1);
        @(negedge clk);
        check("lat_one_cycle", m_cv, 0);

        foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].exp_pass);
        idle(3);
        check("tbl_pass_cnt", m_pc, 5);
        check("tbl_fail_cnt", m_fc, 2);
        check("carry_err_flag", m_ef, 1);
        check("carry_err_tuple", m_et, {4'hF, 4'h1, 1'b0, 4'h0, 1'b0});
        check("carry_err_expected", m_ee, 5'h10);

        do_clear();
        send(4'h3, 4'h4, 1'b1, 4'h7, 1'b0, 1'b0);
        send(4'h1, 4'h1, 1'b0, 4'h3, 1'b0, 1'b0);
        idle(3);
        check("ff_fail_cnt", m_fc, 2);
        check("ff_pass_cnt", m_pc, 0);
        check("ff_err_tuple", m_et, {4'h3, 4'h4, 1'b1, 4'h7, 1'b0});
        check("ff_err_expected", m_ee, 5'h08);

        do_clear();
        check("halt_ready_before", h_ready, 1);
        send(4'h2, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0);
        send(4'h1, 4'h2, 1'b0, 4'h3, 1'b0, 1'b1);
        idle(2);
        check("halt_ready", h_ready, 0);
        check("halt_fail_cnt", h_fc, 1);
        check("halt_pass_cnt", h_pc, 0);
        check("halt_err_flag", h_ef, 1);
        send(4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b1);
        idle(2);
        check("halt_hold_pass", h_pc, 0);
        check("halt_hold_fail", h_fc, 1);
        do_clear();
        check("halt_clr_ready", h_ready, 1);
        check("halt_clr_pass", h_pc, 0);
        check("halt_clr_fail", h_fc, 0);
        check("halt_clr_err", h_ef, 0);

        do_clear();
        for (int i = 0; i < 20; i++) send(4'(i), 4'h0, 1'b0, 4'(i), 1'b0, 1'b1);
        idle(2);
        check("sat_pass_cnt", s_pc, 15);
        check("sat_main_cnt", m_pc, 20);
        send(4'h1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b1);
        idle(2);
        check("sat_hold", s_pc, 15);
        check("sat_fail_cnt", s_fc, 0);

        // Async reset with a tuple sitting in stage 1.
        idle(2);
        send(4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.delete();
        p0 = pulses;
        check("arst_chk_valid", m_cv, 0);
        check("arst_pass_cnt", m_pc, 0);
        check("arst_err_flag", m_ef, 0);
        check("arst_halt_ready", h_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check("arst_no_pulse", pulses, p0);
        check("arst_ready", m_ready, 1);
        check("arst_pass_after", m_pc, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
